// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared definitions for the PC / instruction-fetch sequencer:
// fetch FSM state encoding, the canonical NOP word and the default vectors.
package pc_fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        KILL = 3'd4
    } fetch_state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR           = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    // Redirect targets are word aligned; the low two bits are cleared.
    localparam logic [31:0] WORD_ALIGN_MASK     = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_fetch_sequencer_pc_incrementer.sv
// Sequential-PC adder: pc + 4 built as a ripple of 1-bit full adders.
// The carry out of bit 31 is intentionally dropped, so 0xFFFF_FFFC wraps to 0.
module pc_incrementer (
    input  logic [31:0] pc_i,
    output logic [31:0] pc_plus4_o
);

    localparam logic [31:0] INCREMENT = 32'h0000_0004;

    // 1-bit full adder, returns {carry_out, sum}
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        full_add = {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
    endfunction

    // Ripple the carry from bit 0 up to bit 31; the final carry is discarded
    always_comb begin : ripple
        logic       carry_v;
        logic [1:0] fa_v;
        carry_v    = 1'b0;
        fa_v       = 2'b00;
        pc_plus4_o = 32'h0000_0000;
        for (int i = 0; i < 32; i++) begin
            fa_v          = full_add(pc_i[i], INCREMENT[i], carry_v);
            pc_plus4_o[i] = fa_v[0];
            carry_v       = fa_v[1];
        end
    end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer.
// Issues one imem request at a time, holds the returned instruction for
// decode, and picks the next PC: trap vector > redirect target > pc+4.
// Optional feature macro: PC_FETCH_MISALIGN_TRAP_EN -- a redirect to a
// non-word-aligned target is turned into a trap and flagged on misalign_err.
// Without it, the target's low two bits are cleared and misalign_err is 0.
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap_valid,
    output logic        misalign_err
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  pc_plus4_s;
    logic [31:0]  target_s;
    logic         flush_s;
    logic         misalign_s;

    pc_incrementer u_pc_incrementer (
        .pc_i       (pc_q),
        .pc_plus4_o (pc_plus4_s)
    );

    // Resolve the non-sequential target: trap beats redirect
    always_comb begin
        flush_s    = trap_valid | redirect_valid;
        target_s   = redirect_pc & WORD_ALIGN_MASK;
        misalign_s = 1'b0;
        if (trap_valid) begin
            target_s = TRAP_VECTOR;
        end else if (redirect_valid) begin
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                target_s   = TRAP_VECTOR;
                misalign_s = 1'b1;
            end else begin
                target_s   = redirect_pc & WORD_ALIGN_MASK;
                misalign_s = 1'b0;
            end
`else
            target_s   = redirect_pc & WORD_ALIGN_MASK;
            misalign_s = 1'b0;
`endif
        end else begin
            target_s   = redirect_pc & WORD_ALIGN_MASK;
            misalign_s = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a flush with a response still owed detours through KILL
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_d = flush_s ? KILL : WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    // a response arriving with the flush is simply dropped
                    state_d = flush_s ? REQ : HOLD;
                end else begin
                    state_d = flush_s ? KILL : WAIT;
                end
            end
            HOLD: begin
                if (flush_s || if_ready) begin
                    state_d = REQ;
                end else begin
                    state_d = HOLD;
                end
            end
            KILL: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end else begin
                    state_d = KILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next PC and the instruction capture for decode
    always_comb begin
        if (flush_s) begin
            pc_d = target_s;
        end else if ((state_q == HOLD) && if_ready) begin
            pc_d = pc_plus4_s;
        end else begin
            pc_d = pc_q;
        end

        if ((state_q == WAIT) && imem_rvalid && !flush_s) begin
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
        end else begin
            if_pc_d    = if_pc_q;
            if_instr_d = if_instr_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            if_pc_q    <= RESET_VECTOR;
            if_instr_q <= NOP_INSTR;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic misalign_err_q, misalign_err_d;

    // One-cycle pulse whenever a misaligned redirect is converted to a trap
    always_comb begin
        misalign_err_d = misalign_s;
    end

    // Misalignment flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_err_q <= 1'b0;
        end else begin
            misalign_err_q <= misalign_err_d;
        end
    end

    assign misalign_err = misalign_err_q;
`else
    logic unused_misalign_s;
    assign unused_misalign_s = misalign_s;
    assign misalign_err      = 1'b0;
`endif

    // Outputs decoded from state and registers only
    always_comb begin
        imem_req  = (state_q == REQ);
        imem_addr = pc_q;
        if_valid  = (state_q == HOLD);
        if_pc     = if_pc_q;
        if_instr  = if_instr_q;
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer. Inputs change 1 ns after a rising
// edge and outputs are sampled there too, away from the active edge.
`timescale 1ns/1ps
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic        misalign_err;

    int n_vec  = 0;
    int n_fail = 0;

    pc_fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_ready       (if_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fetch from REQ to HOLD with gnt then rvalid on consecutive edges
    task automatic fetch_to_hold(input logic [31:0] instr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = instr;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; trap_valid = 1'b0;
        tick(); tick();
        n_vec++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr got=%h exp=00000000", imem_addr); end
        n_vec++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
        n_vec++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc got=%h exp=00000000", if_pc); end
        n_vec++; if (if_instr !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_if_instr got=%h exp=00000013", if_instr); end
        n_vec++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL rst_misalign got=%b exp=0", misalign_err); end
        rst = 1'b0;
        #1;
        n_vec++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rel_req_early got=%b exp=0", imem_req); end
        tick();  // first edge after release: IDLE -> REQ
        n_vec++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req got=%b exp=1", imem_req); end
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL seq_req[%0d] got=%b exp=1", k, imem_req); end
            n_vec++; if (imem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_addr[%0d] got=%h exp=%h", k, imem_addr, 32'(4 * k)); end
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0;
            n_vec++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_wait_req[%0d] got=%b exp=0", k, imem_req); end
            imem_rvalid = 1'b1; imem_rdata = 32'h1000_0000 + 32'(k);
            tick();
            imem_rvalid = 1'b0;
            n_vec++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d] got=%b exp=1", k, if_valid); end
            n_vec++; if (if_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_if_pc[%0d] got=%h exp=%h", k, if_pc, 32'(4 * k)); end
            n_vec++; if (if_instr !== 32'h1000_0000 + 32'(k)) begin n_fail++; $display("FAIL seq_instr[%0d] got=%h exp=%h", k, if_instr, 32'h1000_0000 + 32'(k)); end
            if_ready = 1'b1;
            tick();
            if_ready = 1'b0;
            n_vec++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL seq_consumed[%0d] got=%b exp=0", k, if_valid); end
        end
    endtask

    task automatic test_stall();
        // pc = 0xC here
        fetch_to_hold(32'hDEAD_BEEF);
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0000_000C, 32'hDEAD_BEEF})
                begin n_fail++; $display("FAIL stall_hold[%0d] got=%b/%h/%h exp=1/0000000c/deadbeef", c, if_valid, if_pc, if_instr); end
            n_vec++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d] got=%b exp=0", c, imem_req); end
        end
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        n_vec++; if (imem_addr !== 32'h0000_0010) begin n_fail++; $display("FAIL stall_next got=%h exp=00000010", imem_addr); end
    endtask

    task automatic test_redirect_wait();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        tick();  // WAIT -> KILL
        redirect_valid = 1'b0;
        n_vec++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL kill_req got=%b exp=0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        tick();  // stale response discarded
        imem_rvalid = 1'b0;
        n_vec++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL kill_valid got=%b exp=0", if_valid); end
        n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0200}) begin n_fail++; $display("FAIL kill_addr got=%b/%h exp=1/00000200", imem_req, imem_addr); end
        fetch_to_hold(32'h0050_0093);
        n_vec++; if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0000_0200, 32'h0050_0093})
            begin n_fail++; $display("FAIL redir_hold got=%b/%h/%h exp=1/00000200/00500093", if_valid, if_pc, if_instr); end
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        n_vec++; if (imem_addr !== 32'h0000_0204) begin n_fail++; $display("FAIL redir_next got=%h exp=00000204", imem_addr); end
    endtask

    task automatic test_trap_redirect_hold();
        fetch_to_hold(32'h0000_0073);
        trap_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; if_ready = 1'b1;
        tick();
        trap_valid = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
        n_vec++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL trap_valid got=%b exp=0", if_valid); end
        n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0100}) begin n_fail++; $display("FAIL trap_addr got=%b/%h exp=1/00000100", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();  // redirect in REQ without gnt
        redirect_valid = 1'b0;
        n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin n_fail++; $display("FAIL req_redir got=%b/%h exp=1/fffffffc", imem_req, imem_addr); end
        fetch_to_hold(32'h1111_2222);
        n_vec++; if (if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_if_pc got=%h exp=fffffffc", if_pc); end
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0000}) begin n_fail++; $display("FAIL wrap_addr got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_misalign();
        logic [31:0] exp_addr;
        logic        exp_err;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        exp_addr = 32'h0000_0100; exp_err = 1'b1;
`else
        exp_addr = 32'h0000_0200; exp_err = 1'b0;
`endif
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0202;
        tick();
        redirect_valid = 1'b0;
        n_vec++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL mis_addr got=%h exp=%h", imem_addr, exp_addr); end
        n_vec++; if (misalign_err !== exp_err) begin n_fail++; $display("FAIL mis_err got=%b exp=%b", misalign_err, exp_err); end
        tick();
        n_vec++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_pulse got=%b exp=0", misalign_err); end
    endtask

    task automatic test_reset_midflight();
        imem_gnt = 1'b1;
        tick();  // now in WAIT at exp_addr
        imem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        n_vec++; if ({imem_req, imem_addr, if_valid} !== {1'b0, 32'h0, 1'b0}) begin n_fail++; $display("FAIL arst got=%b/%h/%b exp=0/00000000/0", imem_req, imem_addr, if_valid); end
        tick();
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hFEED_FACE;  // late response from before reset
        tick();
        imem_rvalid = 1'b0;
        n_vec++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL arst_req got=%b/%h exp=1/00000000", imem_req, imem_addr); end
        n_vec++; if ({if_valid, if_instr} !== {1'b0, 32'h0000_0013}) begin n_fail++; $display("FAIL arst_stale got=%b/%h exp=0/00000013", if_valid, if_instr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_trap_redirect_hold();
        test_wrap();
        test_misalign();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
